// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a word-addressed data memory, with sub-word store lane
// steering and sign/zero-extending loads. Defining DMEM_ARB_FIXED_PRIO_EN gives port 0 fixed priority.
module dmem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [WIDTH-1:0] p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    input  logic [1:0]       p0_size,
    input  logic             p0_unsigned,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic [WIDTH-1:0] p0_rdata,
    output logic             p0_err,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [WIDTH-1:0] p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    input  logic [1:0]       p1_size,
    input  logic             p1_unsigned,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             p1_err,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-3:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_byteen,
    input  logic [WIDTH-1:0] mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for a request; grant is combinational here
    // ACCESS | txn regs drive the memory port; load data captured at the edge
    // RESP   | owner sees rvalid with the captured response
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_owner_q;
    logic             win;
    logic             grant;
    logic             txn_we, txn_unsigned, txn_owner;
    logic [WIDTH-1:0] txn_addr, txn_wdata;
    logic [1:0]       txn_size;
    logic [WIDTH-1:0] resp_rdata_q;
    logic             resp_err_q;
    logic             txn_err;
    logic             in_access;
    logic [3:0]       byteen_c;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] load_c;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant   = 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    win     = !p0_req;
`else
                    win     = (p0_req && p1_req) ? !last_owner_q : p1_req;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign p0_gnt = rst_n && grant && !win;
    assign p1_gnt = rst_n && grant && win;

    assign txn_err = (txn_size == 2'b11)
                  || (txn_size == 2'b01 && txn_addr[0])
                  || (txn_size == 2'b10 && txn_addr[1:0] != 2'b00);

    always_comb begin
        byteen_c = 4'b0000;
        wdata_c  = txn_wdata;
        load_c   = shifted;
        case (txn_size)
            2'b00: begin
                byteen_c = 4'b0001 << txn_addr[1:0];
                wdata_c  = {4{txn_wdata[7:0]}};
                load_c   = txn_unsigned ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                                        : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                byteen_c = 4'b0011 << {txn_addr[1], 1'b0};
                wdata_c  = {2{txn_wdata[15:0]}};
                load_c   = txn_unsigned ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                                        : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            end
            default: byteen_c = 4'b1111;
        endcase
    end

    assign shifted = mem_rdata >> {txn_addr[1:0], 3'b000};

    // Strobes are gated by rst_n so a store caught by reset in ACCESS never commits
    assign in_access  = rst_n && (state_q == ACCESS) && !txn_err;
    assign mem_read   = in_access && !txn_we;
    assign mem_write  = in_access && txn_we;
    assign mem_byteen = in_access ? byteen_c : 4'b0000;
    assign mem_addr   = txn_addr[WIDTH-1:2];
    assign mem_wdata  = wdata_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            txn_we       <= 1'b0;
            txn_unsigned <= 1'b0;
            txn_owner    <= 1'b0;
            txn_addr     <= '0;
            txn_wdata    <= '0;
            txn_size     <= 2'b00;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_owner_q <= win;
                txn_owner    <= win;
                txn_we       <= win ? p1_we       : p0_we;
                txn_addr     <= win ? p1_addr     : p0_addr;
                txn_wdata    <= win ? p1_wdata    : p0_wdata;
                txn_size     <= win ? p1_size     : p0_size;
                txn_unsigned <= win ? p1_unsigned : p0_unsigned;
            end
            if (state_q == ACCESS) begin
                resp_err_q   <= txn_err;
                resp_rdata_q <= (txn_err || txn_we) ? '0 : load_c;
            end
        end
    end

    assign p0_rvalid = rst_n && (state_q == RESP) && !txn_owner;
    assign p1_rvalid = rst_n && (state_q == RESP) && txn_owner;
    assign p0_rdata  = p0_rvalid ? resp_rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? resp_rdata_q : '0;
    assign p0_err    = p0_rvalid && resp_err_q;
    assign p1_err    = p1_rvalid && resp_err_q;

endmodule
